afifo_wr_ctrl: RTL and testbench

Write-domain pointer and flag controller for the asynchronous FIFO inside the AHB2AHB bridge. It sits directly upstream of the multi-flop synchronizer.
- Produces the registered Gray write pointer that the synchronizer carries into the read domain.
- Consumes the read pointer that a second synchronizer instance has already brought into the write domain.
- Generates the storage write enable and write address, plus the full, almost-full and level outputs.

---
 rtl/afifo_pkg.sv | 23 ++
 rtl/afifo_wr_ctrl_if.sv | 34 +++
 rtl/afifo_ptr_gray.sv | 32 +++
 rtl/afifo_wr_ctrl.sv | 97 +++++++++
 tb/tb_afifo_wr_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Shared pointer helpers for the asynchronous FIFO write and read controllers.
package afifo_pkg;

  localparam int AFIFO_ADDR_WIDTH = 4;
  localparam int AFIFO_PTR_WIDTH  = AFIFO_ADDR_WIDTH + 1;

  // Both conversions work at any width up to 32 bits: callers zero-extend
  // the operand and truncate the result to their own pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b     = '0;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/afifo_wr_ctrl_if.sv
// Write-side bus of the async FIFO: the push request, the synchronized read
// pointer, and the pointer, address and flags the controller produces.
interface afifo_wr_ctrl_if
  import afifo_pkg::*;
#(
  parameter int ADDR_WIDTH = AFIFO_ADDR_WIDTH
) ();

  localparam int PW = ADDR_WIDTH + 1;

  // W_INC is a request and W_EN is its accept: a word is written on every CLK
  // edge where W_EN=1. W_INC may be held while W_FULL=1; it is simply refused.
  logic                  W_INC;
  logic [PW-1:0]         RQ2_RPTR;
  logic                  W_OVF_CLR;
  logic                  W_EN;
  logic [ADDR_WIDTH-1:0] W_ADDR;
  logic [PW-1:0]         WPTR_GRAY;
  logic                  W_FULL;
  logic                  W_ALMOST_FULL;
  logic [PW-1:0]         W_LEVEL;
  logic                  W_OVF;

  modport master (
    output W_INC, RQ2_RPTR, W_OVF_CLR,
    input  W_EN, W_ADDR, WPTR_GRAY, W_FULL, W_ALMOST_FULL, W_LEVEL, W_OVF
  );

  modport slave (
    input  W_INC, RQ2_RPTR, W_OVF_CLR,
    output W_EN, W_ADDR, WPTR_GRAY, W_FULL, W_ALMOST_FULL, W_LEVEL, W_OVF
  );

endinterface

// File: rtl/afifo_ptr_gray.sv
// Binary + Gray pointer register with increment enable; shared by the write
// and read controllers. The Gray copy is a flop so it is safe to synchronize.
module afifo_ptr_gray
  import afifo_pkg::*;
#(
  parameter int PTR_WIDTH = AFIFO_PTR_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 inc,
  output logic [PTR_WIDTH-1:0] bin_q,
  output logic [PTR_WIDTH-1:0] gray_q,
  output logic [PTR_WIDTH-1:0] bin_d,
  output logic [PTR_WIDTH-1:0] gray_d
);

  always_comb begin
    bin_d  = bin_q + PTR_WIDTH'(inc);
    gray_d = PTR_WIDTH'(bin2gray(32'(bin_d)));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

endmodule

// File: rtl/afifo_wr_ctrl.sv
// Write-domain pointer and flag controller of the AHB2AHB bridge async FIFO.
// Optional sticky overflow flag: define AFIFO_WR_OVF_STICKY_EN.
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDR_WIDTH = AFIFO_ADDR_WIDTH,
  parameter int AF_THRESH  = 12
) (
  input  logic            CLK,
  input  logic            RST,
  afifo_wr_ctrl_if.slave  wif
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wbin_d;
  logic [PW-1:0] wgray_q;
  logic [PW-1:0] wgray_d;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] w_level_d;
  logic [PW-1:0] w_level_q;
  logic          w_full_d;
  logic          w_full_q;
  logic          w_af_d;
  logic          w_af_q;
  logic          w_en;
  logic          unused_wbin_msb;

  assign w_en = wif.W_INC & ~w_full_q;

  afifo_ptr_gray #(
    .PTR_WIDTH (PW)
  ) u_wptr (
    .CLK    (CLK),
    .RST    (RST),
    .inc    (w_en),
    .bin_q  (wbin_q),
    .gray_q (wgray_q),
    .bin_d  (wbin_d),
    .gray_d (wgray_d)
  );

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray that means the top two bits differ and the rest match.
  always_comb begin
    rbin_s    = PW'(gray2bin(32'(wif.RQ2_RPTR)));
    w_level_d = wbin_d - rbin_s;
    w_full_d  = (wgray_d == {~wif.RQ2_RPTR[PW-1:PW-2], wif.RQ2_RPTR[PW-3:0]});
    w_af_d    = (w_level_d >= PW'(AF_THRESH));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      w_full_q  <= 1'b0;
      w_af_q    <= 1'b0;
      w_level_q <= '0;
    end else begin
      w_full_q  <= w_full_d;
      w_af_q    <= w_af_d;
      w_level_q <= w_level_d;
    end
  end

`ifdef AFIFO_WR_OVF_STICKY_EN
  logic ovf_d;
  logic ovf_q;

  // A refused push sets the flag; set beats a simultaneous clear.
  always_comb begin
    ovf_d = (wif.W_INC & w_full_q) | (ovf_q & ~wif.W_OVF_CLR);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign wif.W_OVF = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = wif.W_OVF_CLR;
  assign wif.W_OVF      = 1'b0;
`endif

  assign unused_wbin_msb   = wbin_q[PW-1];
  assign wif.W_EN          = w_en;
  assign wif.W_ADDR        = wbin_q[ADDR_WIDTH-1:0];
  assign wif.WPTR_GRAY     = wgray_q;
  assign wif.W_FULL        = w_full_q;
  assign wif.W_ALMOST_FULL = w_af_q;
  assign wif.W_LEVEL       = w_level_q;

endmodule

// File: tb/tb_afifo_wr_ctrl.sv
// Directed bench for afifo_wr_ctrl: fill, refused pushes, read-pointer
// advance, simultaneous push/pop, asynchronous reset and pointer wrap.
module tb_afifo_wr_ctrl;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  logic exp_ovf;
  logic [4:0] exp_q[$];

  afifo_wr_ctrl_if #(.ADDR_WIDTH(4)) wif ();

  afifo_wr_ctrl #(
    .ADDR_WIDTH (4),
    .AF_THRESH  (12)
  ) u_dut (
    .CLK (clk),
    .RST (rst_n),
    .wif (wif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic inc, input logic [4:0] rptr, input logic clr);
    wif.W_INC     = inc;
    wif.RQ2_RPTR  = rptr;
    wif.W_OVF_CLR = clr;
  endtask

  function automatic logic [4:0] tb_gray(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0);
    tick();
    tick();
    tests_run++; if (wif.W_EN !== 1'b0) begin tests_failed++; $display("FAIL reset_w_en got %b exp 0", wif.W_EN); end
    tests_run++; if (wif.W_ADDR !== 4'd0) begin tests_failed++; $display("FAIL reset_w_addr got %0d exp 0", wif.W_ADDR); end
    tests_run++; if (wif.WPTR_GRAY !== 5'd0) begin tests_failed++; $display("FAIL reset_wptr got %b exp 00000", wif.WPTR_GRAY); end
    tests_run++; if (wif.W_FULL !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b exp 0", wif.W_FULL); end
    tests_run++; if (wif.W_ALMOST_FULL !== 1'b0) begin tests_failed++; $display("FAIL reset_af got %b exp 0", wif.W_ALMOST_FULL); end
    tests_run++; if (wif.W_LEVEL !== 5'd0) begin tests_failed++; $display("FAIL reset_level got %0d exp 0", wif.W_LEVEL); end
    tests_run++; if (wif.W_OVF !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got %b exp 0", wif.W_OVF); end
    rst_n = 1'b1;
    tick();
    tests_run++; if (wif.WPTR_GRAY !== 5'd0) begin tests_failed++; $display("FAIL idle_wptr got %b exp 00000", wif.WPTR_GRAY); end
  endtask

  task automatic test_fill();
    logic [4:0] exp_g;
    exp_q = {5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12,
             5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9, 5'd8, 5'd24};
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 5'd0, 1'b0);
      #1;
      tests_run++; if (wif.W_EN !== 1'b1) begin tests_failed++; $display("FAIL fill_w_en k=%0d got %b exp 1", k, wif.W_EN); end
      tests_run++; if (wif.W_ADDR !== 4'(k)) begin tests_failed++; $display("FAIL fill_w_addr k=%0d got %0d exp %0d", k, wif.W_ADDR, k); end
      tick();
      exp_g = exp_q.pop_front();
      tests_run++; if (wif.WPTR_GRAY !== exp_g) begin tests_failed++; $display("FAIL fill_wptr k=%0d got %b exp %b", k, wif.WPTR_GRAY, exp_g); end
      tests_run++; if (wif.W_LEVEL !== 5'(k + 1)) begin tests_failed++; $display("FAIL fill_level k=%0d got %0d exp %0d", k, wif.W_LEVEL, k + 1); end
      tests_run++; if (wif.W_FULL !== (k == 15)) begin tests_failed++; $display("FAIL fill_full k=%0d got %b exp %b", k, wif.W_FULL, (k == 15)); end
      tests_run++; if (wif.W_ALMOST_FULL !== (k + 1 >= 12)) begin tests_failed++; $display("FAIL fill_af k=%0d got %b exp %b", k, wif.W_ALMOST_FULL, (k + 1 >= 12)); end
    end
    drive(1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_push_full();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd0, 1'b0);
      #1;
      tests_run++; if (wif.W_EN !== 1'b0) begin tests_failed++; $display("FAIL pf_w_en k=%0d got %b exp 0", k, wif.W_EN); end
      tick();
      tests_run++; if (wif.WPTR_GRAY !== 5'b11000) begin tests_failed++; $display("FAIL pf_wptr k=%0d got %b exp 11000", k, wif.WPTR_GRAY); end
      tests_run++; if (wif.W_LEVEL !== 5'd16) begin tests_failed++; $display("FAIL pf_level k=%0d got %0d exp 16", k, wif.W_LEVEL); end
      tests_run++; if (wif.W_FULL !== 1'b1) begin tests_failed++; $display("FAIL pf_full k=%0d got %b exp 1", k, wif.W_FULL); end
      tests_run++; if (wif.W_OVF !== exp_ovf) begin tests_failed++; $display("FAIL pf_ovf k=%0d got %b exp %b", k, wif.W_OVF, exp_ovf); end
    end
    drive(1'b0, 5'd0, 1'b1);
    tick();
    tests_run++; if (wif.W_OVF !== 1'b0) begin tests_failed++; $display("FAIL ovf_clr got %b exp 0", wif.W_OVF); end
    drive(1'b1, 5'd0, 1'b1);
    tick();
    tests_run++; if (wif.W_OVF !== exp_ovf) begin tests_failed++; $display("FAIL ovf_set_wins got %b exp %b", wif.W_OVF, exp_ovf); end
    drive(1'b0, 5'd0, 1'b1);
    tick();
    tests_run++; if (wif.W_OVF !== 1'b0) begin tests_failed++; $display("FAIL ovf_clr2 got %b exp 0", wif.W_OVF); end
    tests_run++; if (wif.WPTR_GRAY !== 5'b11000) begin tests_failed++; $display("FAIL pf_wptr_end got %b exp 11000", wif.WPTR_GRAY); end
    drive(1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_rptr_advance();
    drive(1'b0, 5'b00001, 1'b0);
    tick();
    tests_run++; if (wif.W_FULL !== 1'b0) begin tests_failed++; $display("FAIL ra_full got %b exp 0", wif.W_FULL); end
    tests_run++; if (wif.W_LEVEL !== 5'd15) begin tests_failed++; $display("FAIL ra_level got %0d exp 15", wif.W_LEVEL); end
    tests_run++; if (wif.W_ALMOST_FULL !== 1'b1) begin tests_failed++; $display("FAIL ra_af got %b exp 1", wif.W_ALMOST_FULL); end
  endtask

  task automatic test_same_cycle();
    drive(1'b0, 5'b00111, 1'b0);
    tick();
    tests_run++; if (wif.W_LEVEL !== 5'd11) begin tests_failed++; $display("FAIL sc_level_pre got %0d exp 11", wif.W_LEVEL); end
    tests_run++; if (wif.W_ALMOST_FULL !== 1'b0) begin tests_failed++; $display("FAIL sc_af_pre got %b exp 0", wif.W_ALMOST_FULL); end
    drive(1'b1, 5'b00101, 1'b0);
    #1;
    tests_run++; if (wif.W_EN !== 1'b1) begin tests_failed++; $display("FAIL sc_w_en got %b exp 1", wif.W_EN); end
    tests_run++; if (wif.W_ADDR !== 4'd0) begin tests_failed++; $display("FAIL sc_w_addr got %0d exp 0", wif.W_ADDR); end
    tick();
    tests_run++; if (wif.W_LEVEL !== 5'd11) begin tests_failed++; $display("FAIL sc_level got %0d exp 11", wif.W_LEVEL); end
    tests_run++; if (wif.W_ALMOST_FULL !== 1'b0) begin tests_failed++; $display("FAIL sc_af got %b exp 0", wif.W_ALMOST_FULL); end
    tests_run++; if (wif.WPTR_GRAY !== 5'b11001) begin tests_failed++; $display("FAIL sc_wptr got %b exp 11001", wif.WPTR_GRAY); end
    tests_run++; if (wif.W_FULL !== 1'b0) begin tests_failed++; $display("FAIL sc_full got %b exp 0", wif.W_FULL); end
    drive(1'b0, 5'b00101, 1'b0);
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    #2;
    tests_run++; if (wif.WPTR_GRAY !== 5'd0) begin tests_failed++; $display("FAIL ar_wptr got %b exp 00000", wif.WPTR_GRAY); end
    tests_run++; if (wif.W_LEVEL !== 5'd0) begin tests_failed++; $display("FAIL ar_level got %0d exp 0", wif.W_LEVEL); end
    tests_run++; if (wif.W_ADDR !== 4'd0) begin tests_failed++; $display("FAIL ar_w_addr got %0d exp 0", wif.W_ADDR); end
    drive(1'b0, 5'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    logic [4:0] wb;
    logic [4:0] exp_g;
    wb = 5'd0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, tb_gray(wb - 5'd1), 1'b0);
      #1;
      tests_run++; if (wif.W_ADDR !== wb[3:0]) begin tests_failed++; $display("FAIL wrap_w_addr i=%0d got %0d exp %0d", i, wif.W_ADDR, wb[3:0]); end
      tick();
      wb    = wb + 5'd1;
      exp_g = tb_gray(wb);
      tests_run++; if (wif.WPTR_GRAY !== exp_g) begin tests_failed++; $display("FAIL wrap_wptr i=%0d got %b exp %b", i, wif.WPTR_GRAY, exp_g); end
      tests_run++; if (wif.W_LEVEL !== 5'd2) begin tests_failed++; $display("FAIL wrap_level i=%0d got %0d exp 2", i, wif.W_LEVEL); end
      tests_run++; if (wif.W_FULL !== 1'b0) begin tests_failed++; $display("FAIL wrap_full i=%0d got %b exp 0", i, wif.W_FULL); end
    end
    drive(1'b0, tb_gray(wb - 5'd2), 1'b0);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
`ifdef AFIFO_WR_OVF_STICKY_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    test_reset();
    test_fill();
    test_push_full();
    test_rptr_advance();
    test_same_cycle();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
